// File: rtl/alu_add_and_cmp_unit.sv
// alu_add_and_cmp_unit
//   Registered integer ALU slice for the execute stage: ADD, AND, CMP.
//   Result and updated NZCV nibble appear one clock after the operands are
//   accepted. Flags are not stored here; the caller owns the flag register
//   and feeds it back through flag_in.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/op valid this cycle
//   op         00=ADD 01=AND 10=CMP 11=reserved
//   a, b       operands (two's complement, WIDTH bits)
//   s          set-flags enable for ADD/AND (CMP always sets flags)
//   flag_in    current flags {N,Z,C,V}
//   out_valid  registered: result/new_flag valid
//   result     registered operation result
//   wr_en      registered: result should be written back
//   new_flag   registered updated flags {N,Z,C,V}
//
// Build option
//   ALU_ADD_SAT_EN  when defined, ADD saturates on signed overflow
//                   (N/Z from saturated value, V set, C = raw carry).
module alu_add_and_cmp_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic [3:0]       flag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [3:0]       new_flag
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;

  localparam int M = WIDTH - 1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_v;
  logic             w_cmp_v;
  logic [WIDTH-1:0] w_add_res;
  logic [WIDTH-1:0] w_and_res;
  logic [WIDTH-1:0] w_result;
  logic             w_wr_en;
  logic [3:0]       w_flag;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_wr_en;
  logic [3:0]       r_new_flag;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // a - b as a + ~b + 1 so the top bit is the no-borrow carry
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_add_v = (a[M] == b[M]) && (w_sum[M] != a[M]);
  assign w_cmp_v = (a[M] != b[M]) && (w_diff[M] != a[M]);

`ifdef ALU_ADD_SAT_EN
  // Overflow direction follows the (shared) operand sign
  always_comb begin
    w_add_res = w_sum[WIDTH-1:0];
    if (w_add_v)
      w_add_res = a[M] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign w_add_res = w_sum[WIDTH-1:0];
`endif

  assign w_and_res = a & b;

  always_comb begin
    w_result = '0;
    w_wr_en  = 1'b0;
    w_flag   = flag_in;
    case (op)
      OP_ADD: begin
        w_result = w_add_res;
        w_wr_en  = 1'b1;
        if (s)
          w_flag = {w_add_res[M], (w_add_res == '0), w_sum[WIDTH], w_add_v};
      end
      OP_AND: begin
        w_result = w_and_res;
        w_wr_en  = 1'b1;
        if (s)
          w_flag = {w_and_res[M], (w_and_res == '0), flag_in[1:0]};
      end
      OP_CMP: begin
        w_flag = {w_diff[M], (w_diff[WIDTH-1:0] == '0), w_diff[WIDTH], w_cmp_v};
      end
      default: ; // reserved: valid, no writeback, zero result, flags pass through
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_result    <= '0;
      r_new_flag  <= '0;
    end else if (in_valid) begin
      r_out_valid <= 1'b1;
      r_wr_en     <= w_wr_en;
      r_result    <= w_result;
      r_new_flag  <= w_flag;
    end else begin
      // idle: data outputs hold their last value
      r_out_valid <= 1'b0;
      r_wr_en     <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign wr_en     = r_wr_en;
  assign new_flag  = r_new_flag;

endmodule

// File: tb/tb_alu_add_and_cmp_unit.sv
module tb_alu_add_and_cmp_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        s;
  logic [3:0]  flag_in;
  logic        out_valid;
  logic [31:0] result;
  logic        wr_en;
  logic [3:0]  new_flag;

  alu_add_and_cmp_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .s(s), .flag_in(flag_in), .out_valid(out_valid), .result(result),
    .wr_en(wr_en), .new_flag(new_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        wr;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // monitor: compare every presented output against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid got 1 expected 0");
        end else begin
          e = q.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_wr_en"}, {31'b0, wr_en}, {31'b0, e.wr});
          chk({e.name, "_flag"}, {28'b0, new_flag}, {28'b0, e.flg});
        end
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic sf, input logic [3:0] fi,
                       input logic [31:0] er, input logic ew, input logic [3:0] ef);
    exp_t e;
    in_valid = 1'b1; op = o; a = x; b = y; s = sf; flag_in = fi;
    e.name = name; e.res = er; e.wr = ew; e.flg = ef;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input string name, input logic [31:0] hres, input logic [3:0] hflg);
    in_valid = 1'b0; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h1234_5678; s = 1'b1; flag_in = 4'hF;
    @(posedge clk); #1;
    chk({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_wr_en"}, {31'b0, wr_en}, 32'd0);
    chk({name, "_result_hold"}, result, hres);
    chk({name, "_flag_hold"}, {28'b0, new_flag}, {28'b0, hflg});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; op = 2'b00; a = 32'd1; b = 32'd2; s = 1'b1; flag_in = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_wr_en", {31'b0, wr_en}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_flag", {28'b0, new_flag}, 32'd0);
    end
    rst = 1'b0;

    issue("add_1_2", 2'b00, 32'd1, 32'd2, 1'b0, 4'b0000, 32'd3, 1'b1, 4'b0000);
`ifdef ALU_ADD_SAT_EN
    issue("add_pos_ovf", 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b1, 4'b0000, 32'h7FFF_FFFF, 1'b1, 4'b0001);
    issue("add_neg_ovf", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 4'b0000, 32'h8000_0000, 1'b1, 4'b1011);
`else
    issue("add_pos_ovf", 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b1, 4'b0000, 32'h8000_0000, 1'b1, 4'b1001);
    issue("add_neg_ovf", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 4'b0000, 32'h0000_0000, 1'b1, 4'b0111);
`endif
    issue("add_wrap_s1", 2'b00, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'b0000, 32'd0, 1'b1, 4'b0110);
    issue("add_wrap_s0", 2'b00, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'b1010, 32'd0, 1'b1, 4'b1010);
    issue("and_zero", 2'b01, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 4'b0011, 32'd0, 1'b1, 4'b0111);
    issue("and_neg", 2'b01, 32'hF000_00FF, 32'h8000_000F, 1'b1, 4'b0100, 32'h8000_000F, 1'b1, 4'b1000);
    issue("and_s0", 2'b01, 32'hFF, 32'h0F, 1'b0, 4'b0101, 32'h0F, 1'b1, 4'b0101);
    issue("cmp_eq", 2'b10, 32'd5, 32'd5, 1'b0, 4'b0000, 32'd0, 1'b0, 4'b0110);
    issue("cmp_lt", 2'b10, 32'd3, 32'd5, 1'b0, 4'b0000, 32'd0, 1'b0, 4'b1000);
    issue("cmp_ovf", 2'b10, 32'h8000_0000, 32'd1, 1'b0, 4'b0000, 32'd0, 1'b0, 4'b0011);
    idle_check("idle_after_cmp", 32'd0, 4'b0011);

    // streaming: ADD, AND, CMP, reserved back to back
    issue("st_add", 2'b00, 32'd2, 32'd3, 1'b1, 4'b1111, 32'd5, 1'b1, 4'b0000);
    issue("st_and", 2'b01, 32'hFF, 32'h0F, 1'b1, 4'b1111, 32'h0F, 1'b1, 4'b0011);
    issue("st_cmp", 2'b10, 32'd2, 32'd7, 1'b0, 4'b0000, 32'd0, 1'b0, 4'b1000);
    issue("st_rsv", 2'b11, 32'd9, 32'd9, 1'b1, 4'b1010, 32'd0, 1'b0, 4'b1010);
    idle_check("idle_after_stream", 32'd0, 4'b1010);

    issue("add_hold", 2'b00, 32'd1, 32'd2, 1'b1, 4'b1111, 32'd3, 1'b1, 4'b0000);
    idle_check("idle_after_add", 32'd3, 4'b0000);
    idle_check("idle_again", 32'd3, 4'b0000);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
